vec_mem_ctrl: RTL
=================

Name: vec_mem_ctrl

Overview:
Multi-lane vector memory holding no_of_units elements of element_width per word, used for the b/x/r vector stores of the solver datapath.
- Successor to the single-cycle vector RAM: parametrised depth, per-lane write mask, registered read with valid, range checking.
- Hardware clear state machine zeroes the array after reset or on request, then pulses finish.
- Sits between the vector-update units (writers) and the dot-product/matrix units (readers).

Parameters:
element_width, 32, bits per element
no_of_units, 8, elements (lanes) per memory word
depth, 1024, number of words; need not be a power of two
address_width, 10, address bits; must satisfy 2**address_width >= depth

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
clear_req  in  1  request full-array zero clear
busy  out  1  high while clearing; reads/writes ignored
finish  out  1  one-cycle pulse when a clear completes
write_enable  in  1  write strobe
write_mask  in  no_of_units  per-lane write enable; bit i selects lane i
input_write_address  in  address_width  write word address
input_data  in  no_of_units*element_width  write data, lane i at bits [i*element_width +: element_width]
read_enable  in  1  read strobe
input_read_address  in  address_width  read word address
memory_output  out  no_of_units*element_width  registered read data
read_valid  out  1  memory_output updated this cycle
addr_error  out  1  one-cycle pulse: an accepted access had address >= depth

Behaviour:
- Reset values:
  - state=CLEAR, clear_addr=0, busy=1, finish=0.
  - memory_output=0, read_valid=0, addr_error=0.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each edge writes all-zero to mem[clear_addr], then increments clear_addr.
  - On the edge that writes depth-1: go to IDLE, busy<=0, finish<=1 for exactly one cycle.
  - A clear therefore takes depth cycles; first edge with reset low writes address 0.
- IDLE state:
  - clear_req=1 -> CLEAR next edge, clear_addr=0, busy<=1.
  - clear_req has priority over a same-cycle read or write; both are dropped.
- While busy:
  - write_enable, read_enable and clear_req are ignored.
  - read_valid stays 0; memory_output holds its last value.
- Reset mid-clear: restart at address 0; finish is not pulsed for the aborted clear.
- Write (IDLE, write_enable=1, address<depth): lanes with write_mask[i]=1 updated on the edge; other lanes keep their contents. write_mask=0 is a legal no-op.
- Read (IDLE, read_enable=1, address<depth):
  - Latency 1: memory_output and read_valid=1 appear after the edge.
  - read_valid is 0 in any cycle without an accepted read.
  - memory_output holds its value between reads.
- Out of range (address >= depth):
  - Write is dropped.
  - Read returns all-zero data with read_valid=1.
  - addr_error pulses once per offending cycle, even if both ports are out of range.
- Simultaneous read and write, different addresses: both performed.
- Same address: read returns pre-write (old) contents, unless the optional feature below is enabled.
- No arithmetic on data; addresses compared unsigned against depth.

Optional Feature:
VEC_MEM_WR_BYPASS_EN
- Defined: a same-cycle read and write to the same in-range address returns the written lanes' new data merged with unmasked old lanes (write-first).
- Undefined: read-first (old data); no forwarding mux is built.

Decomposition:
- Shared package vec_mem_pkg holds:
  - state encoding typedef (CLEAR, IDLE);
  - lane-slice helper function;
  - default element_width/no_of_units constants shared with the dot-product units.
- One sub-module is natural: vec_mem_lane_ram, a single-lane RAM with write enable and registered read, instantiated no_of_units times.
- The FSM, range check and bypass mux stay in the top.

Test Plan:
- depth=16; deassert reset -> busy=1 for 16 cycles, finish pulses once on cycle 16; every address then reads 0 with read_valid=1 one cycle after read_enable.
- Write addr 3, data lanes 0..7 = 0x11..0x88, mask 8'hFF; read addr 3 next cycle -> memory_output lanes 0x11..0x88, read_valid=1.
- Then write addr 3, data all 0xFFFFFFFF, mask 8'h05 -> read gives lanes 0,2 = 0xFFFFFFFF, others unchanged.
- Read and write addr 5 same cycle, old=0, new=0xA5 all lanes -> 0 without VEC_MEM_WR_BYPASS_EN, 0xA5 lanes with it.
- Write addr 16, read addr 20 (depth=16) -> write dropped, read returns 0 with read_valid=1, addr_error single pulse.
- clear_req in IDLE with write_enable same cycle -> write dropped, busy 16 cycles, finish pulse.
- Assert reset at clear cycle 7 -> restart, 16 busy cycles after release, single finish.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared definitions for the multi-lane vector memory: state encoding, lane slicing
// helper and default element geometry shared with the dot-product units.
package vec_mem_pkg;

    localparam int ELEMENT_WIDTH = 32;
    localparam int NO_OF_UNITS   = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Low bit index of a lane within a packed multi-lane word.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/vec_mem_lane_ram.sv
// Single-lane word RAM: one write port, one registered read-first read port.
// Callers guarantee addresses are below depth before asserting an enable.
module vec_mem_lane_ram
    import vec_mem_pkg::*;
#(
    parameter int width         = ELEMENT_WIDTH,
    parameter int depth         = 1024,
    parameter int address_width = 10
) (
    input  logic                     clk,
    input  logic                     write_enable,
    input  logic [address_width-1:0] write_address,
    input  logic [width-1:0]         write_data,
    input  logic                     read_enable,
    input  logic [address_width-1:0] read_address,
    output logic [width-1:0]         read_data
);

    localparam int IDX_W = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] mem [depth];

    // Only the low index bits are needed once the address is known to be in range.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address[IDX_W-1:0]] <= write_data;
        end
        if (read_enable) begin
            read_data <= mem[read_address[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/vec_mem_ctrl.sv
// Multi-lane vector memory with hardware clear FSM, per-lane write mask, range check.
// Optional macro VEC_MEM_WR_BYPASS_EN makes same-address read/write return write-first data.
module vec_mem_ctrl
    import vec_mem_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS,
    parameter int depth         = 1024,
    parameter int address_width = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear_req,
    output logic                                 busy,
    output logic                                 finish,
    input  logic                                 write_enable,
    input  logic [no_of_units-1:0]               write_mask,
    input  logic [address_width-1:0]             input_write_address,
    input  logic [no_of_units*element_width-1:0] input_data,
    input  logic                                 read_enable,
    input  logic [address_width-1:0]             input_read_address,
    output logic [no_of_units*element_width-1:0] memory_output,
    output logic                                 read_valid,
    output logic                                 addr_error
);

    localparam int VEC_W = no_of_units * element_width;
    localparam logic [address_width:0]   DEPTH_L   = (address_width+1)'(depth);
    localparam logic [address_width-1:0] LAST_ADDR = address_width'(depth - 1);

    state_t                   state_q, state_d;
    logic [address_width-1:0] clear_addr_q, clear_addr_d;
    logic                     finish_q, finish_d;

    logic idle, wr_acc, rd_acc, wr_range, rd_range, wr_in, rd_in, addr_err_d;

    logic [address_width-1:0] ram_waddr;
    logic [VEC_W-1:0]         ram_wdata;
    logic [VEC_W-1:0]         ram_rdata;

    logic             vld_p1, oor_p1, addr_error_p1;
    logic [VEC_W-1:0] out_q, out_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            finish_q     <= finish_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        finish_d     = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_addr_d = clear_addr_q + address_width'(1);
                if (clear_addr_q == LAST_ADDR) begin
                    state_d      = IDLE;
                    clear_addr_d = '0;
                    finish_d     = 1'b1;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d      = CLEAR;
                    clear_addr_d = '0;
                end
            end
        endcase
    end

    assign busy   = (state_q == CLEAR);
    assign finish = finish_q;

    // A clear request wins over any same-cycle access.
    assign idle       = (state_q == IDLE);
    assign wr_acc     = idle & ~clear_req & write_enable;
    assign rd_acc     = idle & ~clear_req & read_enable;
    assign wr_range   = ({1'b0, input_write_address} < DEPTH_L);
    assign rd_range   = ({1'b0, input_read_address} < DEPTH_L);
    assign wr_in      = wr_acc & wr_range;
    assign rd_in      = rd_acc & rd_range;
    assign addr_err_d = (wr_acc & ~wr_range) | (rd_acc & ~rd_range);

    assign ram_waddr = busy ? clear_addr_q : input_write_address;
    assign ram_wdata = busy ? '0 : input_data;

    for (genvar i = 0; i < no_of_units; i++) begin : g_lane
        logic lane_we;
        assign lane_we = busy | (wr_in & write_mask[i]);

        vec_mem_lane_ram #(
            .width         (element_width),
            .depth         (depth),
            .address_width (address_width)
        ) u_ram (
            .clk           (clk),
            .write_enable  (lane_we),
            .write_address (ram_waddr),
            .write_data    (ram_wdata[lane_lo(i, element_width) +: element_width]),
            .read_enable   (rd_in),
            .read_address  (input_read_address),
            .read_data     (ram_rdata[lane_lo(i, element_width) +: element_width])
        );
    end

    // ---- stage p1: read result qualification ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            oor_p1        <= 1'b0;
            addr_error_p1 <= 1'b0;
        end else begin
            vld_p1        <= rd_acc;
            oor_p1        <= rd_acc & ~rd_range;
            addr_error_p1 <= addr_err_d;
        end
    end

`ifdef VEC_MEM_WR_BYPASS_EN
    logic                   byp_p1;
    logic [no_of_units-1:0] wmask_p1;
    logic [VEC_W-1:0]       wdata_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_p1 <= 1'b0;
        end else begin
            byp_p1 <= wr_in & rd_in & (input_write_address == input_read_address);
        end
    end

    always_ff @(posedge clk) begin
        wmask_p1 <= write_mask;
        wdata_p1 <= input_data;
    end
`endif

    // Output holds between reads; the hold register clears on reset.
    always_comb begin
        out_d = out_q;
        if (vld_p1) begin
            out_d = oor_p1 ? '0 : ram_rdata;
`ifdef VEC_MEM_WR_BYPASS_EN
            if (byp_p1) begin
                for (int i = 0; i < no_of_units; i++) begin
                    if (wmask_p1[i]) begin
                        out_d[lane_lo(i, element_width) +: element_width] =
                            wdata_p1[lane_lo(i, element_width) +: element_width];
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign memory_output = out_d;
    assign read_valid    = vld_p1;
    assign addr_error    = addr_error_p1;

endmodule
